// File: rtl/subleq_pkg.sv
// subleq_pkg: shared state encoding and word geometry for the SUBLEQ sequencer
package subleq_pkg;
    typedef enum logic [3:0] {IDLE, RD_A, RD_B, RD_C, LD_A, LD_B, EXEC, HALT, FAULT} state_t;
    localparam int WORD_W = 64;
    localparam int INSTR_WORDS = 3;
endpackage

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: fetch/load/subtract/branch sequencer driving a single-port 64-bit word memory
module subleq_ctrl
    import subleq_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter logic [WORD_W-1:0] START_PC = '0,
    parameter int MAX_INSTR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [WORD_W-1:0] pc,
    output logic [31:0]       instr_count
);
    state_t state;
    logic [WORD_W-1:0] a_ptr, b_ptr, c_tgt, a_val, res;
    logic access, addr_ok, leq, limit;

    function automatic logic in_range(input logic [WORD_W-1:0] a);
        return (a >> ADDR_W) == '0;
    endfunction

    // rst gates the strobes combinationally so a reset landing in EXEC never lets the write through
    always_comb begin
        mem_addr = state == RD_A ? pc :
                   state == RD_B ? pc + WORD_W'(1) :
                   state == RD_C ? pc + WORD_W'(2) :
                   state == LD_A ? a_ptr : b_ptr;
        access = state inside {RD_A, RD_B, RD_C, LD_A, LD_B};
        addr_ok = in_range(mem_addr);
        mem_re = access && addr_ok && !rst;
        mem_we = state == EXEC && !rst;
        res = mem_rdata - a_val;
        mem_wdata = res;
        leq = $signed(res) <= 64'sd0;
        limit = MAX_INSTR != 0 && instr_count + 32'd1 == 32'(MAX_INSTR);
        busy = access || state == EXEC;
        halted = state == HALT;
        fault = state == FAULT || (access && !addr_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= START_PC;
            instr_count <= '0;
            a_ptr <= '0;
            b_ptr <= '0;
            c_tgt <= '0;
            a_val <= '0;
        end else begin
            case (state)
                IDLE, HALT: if (start) begin
                    state <= RD_A;
                    pc <= START_PC;
                    instr_count <= '0;
                end
                RD_A: state <= addr_ok ? RD_B : FAULT;
                RD_B: begin
                    a_ptr <= mem_rdata;
                    state <= addr_ok ? RD_C : FAULT;
                end
                RD_C: begin
                    b_ptr <= mem_rdata;
                    state <= addr_ok ? LD_A : FAULT;
                end
                LD_A: begin
                    c_tgt <= mem_rdata;
                    state <= addr_ok ? LD_B : FAULT;
                end
                LD_B: begin
                    a_val <= mem_rdata;
                    state <= addr_ok ? EXEC : FAULT;
                end
                EXEC: begin
                    instr_count <= instr_count + 32'd1;
                    if (limit || (leq && c_tgt[WORD_W-1])) state <= HALT;
                    else begin
                        state <= RD_A;
                        pc <= leq ? c_tgt : pc + WORD_W'(INSTR_WORDS);
                    end
                end
                FAULT: state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: randomized and directed checks of subleq_ctrl against an instruction-level SUBLEQ model
module tb_subleq_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic start [2] = '{1'b0, 1'b0};
    logic ld [2] = '{1'b0, 1'b0};
    logic we [2], re [2], busy [2], halted [2], fault [2];
    logic [63:0] addr [2], wdata [2], rdata [2], pc [2];
    logic [31:0] cnt [2];
    logic [63:0] mem0 [1024], mem1 [1024], img [1024], exp_mem [1024];
    int wcnt [2] = '{0, 0};
    int vec = 0, bad = 0;
    logic [63:0] epc;
    int ecnt, ecyc;
    logic ehalt, eflt, ewd;

    always #5 clk = ~clk;

    subleq_ctrl d0 (.clk(clk), .rst(rst), .start(start[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_we(we[0]), .mem_re(re[0]), .mem_rdata(rdata[0]), .busy(busy[0]), .halted(halted[0]),
        .fault(fault[0]), .pc(pc[0]), .instr_count(cnt[0]));
    subleq_ctrl #(.MAX_INSTR(3)) d1 (.clk(clk), .rst(rst), .start(start[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_we(we[1]), .mem_re(re[1]), .mem_rdata(rdata[1]), .busy(busy[1]),
        .halted(halted[1]), .fault(fault[1]), .pc(pc[1]), .instr_count(cnt[1]));

    always @(posedge clk) begin
        if (ld[0]) mem0 <= img;
        if (ld[1]) mem1 <= img;
        if (we[0]) begin mem0[addr[0][9:0]] <= wdata[0]; wcnt[0] <= wcnt[0] + 1; end
        if (we[1]) begin mem1[addr[1][9:0]] <= wdata[1]; wcnt[1] <= wcnt[1] + 1; end
        if (re[0]) rdata[0] <= mem0[addr[0][9:0]];
        if (re[1]) rdata[1] <= mem1[addr[1][9:0]];
    end

    // Instruction-level model: final memory, pc, count, outcome and cycles from start accept to HALT/FAULT
    task automatic ref_run(input int maxi);
        logic [63:0] a, b, c, r;
        exp_mem = img; epc = 0; ecnt = 0; ecyc = 0; ehalt = 0; eflt = 0; ewd = 0;
        while (!ehalt && !eflt && ecnt < 5000) begin
            if (epc >= 1024) begin eflt = 1; ecyc += 1; end
            else if (epc + 64'd1 >= 1024) begin eflt = 1; ecyc += 2; end
            else if (epc + 64'd2 >= 1024) begin eflt = 1; ecyc += 3; end
            else begin
                a = exp_mem[int'(epc)]; b = exp_mem[int'(epc) + 1]; c = exp_mem[int'(epc) + 2];
                if (a >= 1024) begin eflt = 1; ecyc += 4; end
                else if (b >= 1024) begin eflt = 1; ecyc += 5; end
                else begin
                    r = exp_mem[int'(b)] - exp_mem[int'(a)];
                    exp_mem[int'(b)] = r; ecnt++; ecyc += 6;
                    if (maxi != 0 && ecnt == maxi) begin ehalt = 1; ewd = 1; end
                    else if ($signed(r) <= 0 && c[63]) ehalt = 1;
                    else epc = $signed(r) <= 0 ? c : epc + 64'd3;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    task automatic load(input int s);
        @(negedge clk); ld[s] = 1;
        @(negedge clk); ld[s] = 0;
    endtask

    task automatic go(input int s, output int cyc);
        @(negedge clk); start[s] = 1;
        @(negedge clk); start[s] = 0; cyc = 0;
        while (!(halted[s] || (fault[s] && !busy[s])) && cyc < 400) begin @(negedge clk); cyc++; end
        vec++; if (cyc >= 400) begin bad++; $display("FAIL go_timeout dut%0d no halt/fault after %0d cycles", s, cyc); end
    endtask

    task automatic taken_prog(input logic [63:0] m7);
        img = '{default: '0};
        img[0] = 6; img[1] = 7; img[2] = 3; img[3] = 8; img[4] = 8; img[5] = '1;
        img[6] = 5; img[7] = m7; img[8] = 9;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vec++; if (busy[s] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got %b want 0", s, busy[s]); end
            vec++; if (halted[s] !== 1'b0) begin bad++; $display("FAIL reset_halted dut%0d got %b want 0", s, halted[s]); end
            vec++; if (fault[s] !== 1'b0) begin bad++; $display("FAIL reset_fault dut%0d got %b want 0", s, fault[s]); end
            vec++; if (pc[s] !== 64'd0) begin bad++; $display("FAIL reset_pc dut%0d got %h want 0", s, pc[s]); end
            vec++; if (cnt[s] !== 32'd0) begin bad++; $display("FAIL reset_cnt dut%0d got %0d want 0", s, cnt[s]); end
            vec++; if (re[s] !== 1'b0 || we[s] !== 1'b0) begin bad++; $display("FAIL reset_strobes dut%0d got re=%b we=%b want 0 0", s, re[s], we[s]); end
        end
        rst = 0;
    endtask

    task automatic test_branch();
        logic [63:0] m7 [2] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5};
        int cyc, diff;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            taken_prog(v == 0 ? 64'd2 : 64'd10);
            load(0); ref_run(0); go(0, cyc);
            diff = 0;
            for (int i = 0; i < 1024; i++) if (mem0[i] !== exp_mem[i]) diff++;
            vec++; if (mem0[7] !== m7[v]) begin bad++; $display("FAIL branch%0d_mem7 got %h want %h", v, mem0[7], m7[v]); end
            vec++; if (mem0[8] !== 64'd0) begin bad++; $display("FAIL branch%0d_mem8 got %h want 0", v, mem0[8]); end
            vec++; if (diff != 0) begin bad++; $display("FAIL branch%0d_memory got %0d differing words want 0", v, diff); end
            vec++; if (cyc != 12 || cyc != ecyc) begin bad++; $display("FAIL branch%0d_cycles got %0d want 12 (model %0d)", v, cyc, ecyc); end
            vec++; if (halted[0] !== 1'b1) begin bad++; $display("FAIL branch%0d_halted got %b want 1", v, halted[0]); end
            vec++; if (cnt[0] !== 32'd2) begin bad++; $display("FAIL branch%0d_cnt got %0d want 2", v, cnt[0]); end
            vec++; if (pc[0] !== 64'd3 || pc[0] !== epc) begin bad++; $display("FAIL branch%0d_pc got %h want 3", v, pc[0]); end
        end
    endtask

    task automatic test_fault();
        int w0;
        do_reset();
        img = '{default: '0}; img[0] = 64'd1024;
        load(0); w0 = wcnt[0];
        @(negedge clk); start[0] = 1;
        @(negedge clk); start[0] = 0;
        repeat (3) @(negedge clk);
        vec++; if (fault[0] !== 1'b1 || re[0] !== 1'b0) begin bad++; $display("FAIL fault_lda got fault=%b re=%b want 1 0", fault[0], re[0]); end
        @(negedge clk);
        vec++; if (fault[0] !== 1'b1 || busy[0] !== 1'b0 || halted[0] !== 1'b0) begin bad++; $display("FAIL fault_state got fault=%b busy=%b halted=%b want 1 0 0", fault[0], busy[0], halted[0]); end
        start[0] = 1; @(negedge clk); start[0] = 0; @(negedge clk);
        vec++; if (fault[0] !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL fault_start_ignored got fault=%b busy=%b want 1 0", fault[0], busy[0]); end
        vec++; if (wcnt[0] != w0) begin bad++; $display("FAIL fault_no_write got %0d writes want 0", wcnt[0] - w0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        taken_prog(64'd2); load(0);
        @(negedge clk); start[0] = 1;
        @(negedge clk); start[0] = 0;
        repeat (5) @(negedge clk);
        vec++; if (we[0] !== 1'b1) begin bad++; $display("FAIL midrst_exec_we got %b want 1", we[0]); end
        rst = 1; #1;
        vec++; if (we[0] !== 1'b0) begin bad++; $display("FAIL midrst_we got %b want 0", we[0]); end
        @(negedge clk); rst = 0;
        vec++; if (mem0[7] !== 64'd2) begin bad++; $display("FAIL midrst_mem7 got %h want 2", mem0[7]); end
        vec++; if (pc[0] !== 64'd0 || busy[0] !== 1'b0) begin bad++; $display("FAIL midrst_state got pc=%h busy=%b want 0 0", pc[0], busy[0]); end
    endtask

    task automatic test_restart();
        int cyc, diff;
        do_reset();
        taken_prog(64'd2); load(0); ref_run(0);
        @(negedge clk); start[0] = 1;
        @(negedge clk); start[0] = 0;
        repeat (7) @(negedge clk);
        start[0] = 1; @(negedge clk); start[0] = 0; cyc = 8;
        vec++; if (pc[0] !== 64'd3 || busy[0] !== 1'b1) begin bad++; $display("FAIL busy_start_ignored got pc=%h busy=%b want 3 1", pc[0], busy[0]); end
        while (!halted[0] && cyc < 400) begin @(negedge clk); cyc++; end
        vec++; if (cyc != 12 || cnt[0] !== 32'd2) begin bad++; $display("FAIL busy_start_run got cyc=%0d cnt=%0d want 12 2", cyc, cnt[0]); end
        img = exp_mem; ref_run(0);
        @(negedge clk); start[0] = 1;
        @(negedge clk); start[0] = 0; cyc = 0;
        vec++; if (halted[0] !== 1'b0 || cnt[0] !== 32'd0 || pc[0] !== 64'd0 || busy[0] !== 1'b1) begin bad++; $display("FAIL restart_entry got halted=%b cnt=%0d pc=%h busy=%b want 0 0 0 1", halted[0], cnt[0], pc[0], busy[0]); end
        while (!halted[0] && cyc < 400) begin @(negedge clk); cyc++; end
        diff = 0;
        for (int i = 0; i < 1024; i++) if (mem0[i] !== exp_mem[i]) diff++;
        vec++; if (cyc != ecyc || cnt[0] !== 32'(ecnt)) begin bad++; $display("FAIL restart_run got cyc=%0d cnt=%0d want %0d %0d", cyc, cnt[0], ecyc, ecnt); end
        vec++; if (diff != 0 || mem0[7] !== 64'hFFFF_FFFF_FFFF_FFF8) begin bad++; $display("FAIL restart_mem got mem7=%h diff=%0d want fff..f8 0", mem0[7], diff); end
    endtask

    task automatic test_watchdog();
        int cyc, w0;
        do_reset();
        img = '{default: '0}; img[0] = 9; img[1] = 9; img[2] = 0; img[9] = 64'd77;
        load(1); w0 = wcnt[1]; go(1, cyc);
        vec++; if (wcnt[1] - w0 != 3) begin bad++; $display("FAIL wd_writes got %0d want 3", wcnt[1] - w0); end
        vec++; if (cnt[1] !== 32'd3 || halted[1] !== 1'b1) begin bad++; $display("FAIL wd_state got cnt=%0d halted=%b want 3 1", cnt[1], halted[1]); end
        vec++; if (cyc != 18 || mem1[9] !== 64'd0) begin bad++; $display("FAIL wd_run got cyc=%0d mem9=%h want 18 0", cyc, mem1[9]); end
    endtask

    task automatic test_random();
        int cyc, diff, r;
        for (int n = 0; n < 25; n++) begin
            do_reset();
            img = '{default: '0};
            for (int i = 0; i < 16; i++) begin
                r = int'($urandom_range(0, 15));
                img[i] = r < 12 ? 64'($urandom_range(0, 20)) : r < 14 ? 64'd1024 + 64'($urandom_range(0, 5)) : {1'b1, 31'($urandom), 32'($urandom)};
            end
            for (int i = 16; i < 32; i++) img[i] = {32'($urandom), 32'($urandom)};
            load(1); ref_run(3); go(1, cyc);
            diff = 0;
            for (int i = 0; i < 1024; i++) if (mem1[i] !== exp_mem[i]) diff++;
            vec++; if (halted[1] !== ehalt || (fault[1] && !busy[1]) !== eflt) begin bad++; $display("FAIL rand%0d_outcome got halted=%b fault=%b want %b %b", n, halted[1], fault[1], ehalt, eflt); end
            vec++; if (cnt[1] !== 32'(ecnt) || cyc != ecyc) begin bad++; $display("FAIL rand%0d_timing got cnt=%0d cyc=%0d want %0d %0d", n, cnt[1], cyc, ecnt, ecyc); end
            vec++; if (diff != 0) begin bad++; $display("FAIL rand%0d_memory got %0d differing words want 0", n, diff); end
            if (!ewd) begin
                vec++; if (pc[1] !== epc) begin bad++; $display("FAIL rand%0d_pc got %h want %h", n, pc[1], epc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_fault();
        test_reset_mid();
        test_restart();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/subleq_ctrl.md
Name: subleq_ctrl

Overview:
- Sequencer for the SUBLEQ CPU. Drives the single-port 64-bit word memory (1-cycle registered read, synchronous write) through fetch, operand load, subtract/write-back and branch.
- One instruction is three consecutive words at pc: A, B, C.
- Semantics: mem[B] <= mem[B] - mem[A]; if the result is <= 0 (signed), pc <= C; otherwise pc <= pc+3.
- Sits between the top-level testbench/start logic and the memory block. It is the memory's only requester.

Parameters:
- ADDR_W, 10: implemented memory address bits. Any address with bits [63:ADDR_W] nonzero is a fault.
- START_PC, 0: pc loaded on reset and on each accepted start.
- MAX_INSTR, 0: watchdog instruction limit. 0 means unlimited.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin execution; sampled only in IDLE or HALT
- mem_addr  out  64  memory address
- mem_wdata  out  64  write data
- mem_we  out  1  write enable
- mem_re  out  1  read enable
- mem_rdata  in  64  memory data_out; valid the cycle after mem_re
- busy  out  1  high in any execute state
- halted  out  1  program reached halt or watchdog limit
- fault  out  1  out-of-range address encountered
- pc  out  64  current program counter
- instr_count  out  32  completed instructions since start

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-instruction):
  - state = IDLE; pc = START_PC; instr_count = 0; busy = halted = fault = 0.
  - mem_re = mem_we = 0 in the same cycle the state is reset; no partial write may complete.
- mem_addr, mem_re, mem_we and mem_wdata decode from state and internal registers. Internal registers: a_ptr, b_ptr, c_tgt, a_val.
- States, with the action in each state and the register captured on exit:
  - IDLE: start = 1 -> pc <= START_PC, instr_count <= 0, go to RD_A.
  - RD_A: re = 1, addr = pc.
  - RD_B: re = 1, addr = pc+1; capture a_ptr <= rdata.
  - RD_C: re = 1, addr = pc+2; capture b_ptr <= rdata.
  - LD_A: re = 1, addr = a_ptr; capture c_tgt <= rdata.
  - LD_B: re = 1, addr = b_ptr; capture a_val <= rdata.
  - EXEC:
    - res = rdata - a_val, 64-bit two's complement, wrap on overflow (no saturation).
    - we = 1, addr = b_ptr, wdata = res; instr_count++.
    - res <= 0 signed and c_tgt[63] = 1 -> HALT.
    - res <= 0 signed otherwise -> pc <= c_tgt, go to RD_A.
    - res > 0 -> pc <= pc+3, go to RD_A.
  - HALT: halted = 1, busy = 0. start = 1 -> restart exactly as from IDLE, clearing halted.
  - FAULT: fault = 1, busy = 0. Exit only by rst.
- Timing: 6 cycles per instruction. First read issues the cycle after start is accepted.
- pc+1, pc+2 and pc+3 are 64-bit with natural wrap. Wrapped values are then subject to the range check.
- Range check runs before issuing any access; fail -> FAULT with no access issued.
  - Checked: pc+k in RD_A/RD_B/RD_C; a_ptr in LD_A; b_ptr in LD_B.
  - In EXEC, b_ptr has already passed the check.
  - A C target that fails the check while the branch is not taken is ignored.
  - A taken C target that fails the check faults at the next RD_A. Exception: C negative means halt, not fault.
- Watchdog: MAX_INSTR != 0 and instr_count reaches MAX_INSTR in EXEC -> HALT after the write completes.
- start while busy, or while in FAULT: ignored.
- A = B is legal: the result is 0, so the branch is taken. A read of b_ptr after a prior write returns the written value, because the write happens in EXEC and the next read is at least one cycle later.

Decomposition:
- subleq_pkg holds: state enum (IDLE, RD_A, RD_B, RD_C, LD_A, LD_B, EXEC, HALT, FAULT), WORD_W = 64, INSTR_WORDS = 3.
- Single module; no sub-module is warranted. The range check is a local function.

Test Plan:
- Taken branch: mem[0..2] = 6,7,3; mem[3..5] = 8,8,FFFF_FFFF_FFFF_FFFF; mem[6] = 5, mem[7] = 2, mem[8] = 9. Pulse start -> write mem[7] = FFFF_FFFF_FFFF_FFFD, pc = 3, then write mem[8] = 0, halted = 1 twelve cycles after start accept, instr_count = 2.
- Not taken: same program with mem[7] = 10 -> mem[7] = 5, pc = 3 (pc+3), then halt; instr_count = 2.
- Fault: mem[0] = 1024 with ADDR_W = 10 -> fault = 1 in the LD_A cycle, mem_re = 0 in that cycle, mem_we never asserted, halted = 0.
- Reset mid-instruction: assert rst in the EXEC cycle -> mem_we = 0 that cycle, target word unchanged, pc = 0, busy = 0 next cycle.
- Start/restart: start during RD_B is ignored (no pc change). start in HALT re-runs from pc = 0 with instr_count reset to 0.
- Watchdog: MAX_INSTR = 3, program loops forever (mem[0..2] = 9,9,0) -> halted after exactly 3 EXEC writes, instr_count = 3.
